// File: rtl/rename_map.sv
// rtl/rename_map.sv - two-wide register rename stage with RAT and circular free list
module rename_map #(
  parameter int NUM_AREGS = 32,
  parameter int NUM_PREGS = 128,
  parameter int CTRL_W    = 32,
  localparam int AW = $clog2(NUM_AREGS),
  localparam int PW = $clog2(NUM_PREGS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [1:0]             i_valid,
  input  logic [1:0][AW-1:0]     i_src0,
  input  logic [1:0][AW-1:0]     i_src1,
  input  logic [1:0][AW-1:0]     i_dst,
  input  logic [1:0]             i_regwrite,
  input  logic [1:0][CTRL_W-1:0] i_ctrl,
  output logic                   o_ready,
  input  logic                   i_ready,
  output logic [1:0]             o_valid,
  output logic [1:0][PW-1:0]     o_psrc0,
  output logic [1:0][PW-1:0]     o_psrc1,
  output logic [1:0][PW-1:0]     o_pdst,
  output logic [1:0][PW-1:0]     o_old_pdst,
  output logic [1:0][CTRL_W-1:0] o_ctrl,
  input  logic [1:0]             i_free_valid,
  input  logic [1:0][PW-1:0]     i_free_preg,
  output logic [PW:0]            o_free_count,
  output logic                   o_err
);

  logic [PW-1:0] rat [NUM_AREGS];
  logic [PW-1:0] free_list [NUM_PREGS];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;

  logic [1:0]          alloc;
  logic [PW:0]         need;
  logic                accept;
  logic [PW-1:0]       new0, new1;
  logic [1:0][PW-1:0]  psrc0_n, psrc1_n, pdst_n, old_n;
  logic [1:0]          push_req;
  logic                push0, push1, drop;
  logic [PW:0]         base, base1, count_n;
  logic [PW-1:0]       tail1;

  always_comb begin
    for (int k = 0; k < 2; k++)
      alloc[k] = i_valid[k] && i_regwrite[k] && (i_dst[k] != '0);
    need    = (PW+1)'(alloc[0]) + (PW+1)'(alloc[1]);
    o_ready = ((o_valid == 2'b00) || i_ready) && (count >= need);
    accept  = (|i_valid) && o_ready;

    new0 = free_list[head];
    new1 = alloc[0] ? free_list[head + PW'(1)] : free_list[head];

    for (int k = 0; k < 2; k++) begin
      psrc0_n[k] = (i_src0[k] == '0) ? '0 : rat[i_src0[k]];
      psrc1_n[k] = (i_src1[k] == '0) ? '0 : rat[i_src1[k]];
    end
    // lane 1 must observe lane 0's fresh mapping within the same group
    if (alloc[0] && (i_src0[1] == i_dst[0])) psrc0_n[1] = new0;
    if (alloc[0] && (i_src1[1] == i_dst[0])) psrc1_n[1] = new0;

    pdst_n[0] = alloc[0] ? new0 : '0;
    pdst_n[1] = alloc[1] ? new1 : '0;
    old_n[0]  = alloc[0] ? rat[i_dst[0]] : '0;
    old_n[1]  = '0;
    if (alloc[1])
      old_n[1] = (alloc[0] && (i_dst[1] == i_dst[0])) ? new0 : rat[i_dst[1]];

    for (int k = 0; k < 2; k++)
      push_req[k] = i_free_valid[k] && (i_free_preg[k] != '0);
    // capacity is judged after this cycle's allocations leave the list
    base    = count - (accept ? need : '0);
    push0   = push_req[0] && (base < (PW+1)'(NUM_PREGS-1));
    base1   = base + (PW+1)'(push0);
    push1   = push_req[1] && (base1 < (PW+1)'(NUM_PREGS-1));
    drop    = (push_req[0] && !push0) || (push_req[1] && !push1);
    count_n = base1 + (PW+1)'(push1);
    tail1   = tail + PW'(push0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int a = 0; a < NUM_AREGS; a++)
        rat[a] <= PW'(a);
    end else if (accept) begin
      if (alloc[0]) rat[i_dst[0]] <= new0;
      if (alloc[1]) rat[i_dst[1]] <= new1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_PREGS; i++)
        free_list[i] <= (i < NUM_PREGS - NUM_AREGS) ? PW'(i + NUM_AREGS) : '0;
    end else begin
      if (push0) free_list[tail]  <= i_free_preg[0];
      if (push1) free_list[tail1] <= i_free_preg[1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head  <= '0;
      tail  <= PW'(NUM_PREGS - NUM_AREGS);
      count <= (PW+1)'(NUM_PREGS - NUM_AREGS);
      o_err <= 1'b0;
    end else begin
      if (accept) head <= head + need[PW-1:0];
      tail  <= tail + PW'(push0) + PW'(push1);
      count <= count_n;
      if (drop) o_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid    <= '0;
      o_psrc0    <= '0;
      o_psrc1    <= '0;
      o_pdst     <= '0;
      o_old_pdst <= '0;
      o_ctrl     <= '0;
    end else if (accept) begin
      o_valid    <= i_valid;
      o_psrc0    <= psrc0_n;
      o_psrc1    <= psrc1_n;
      o_pdst     <= pdst_n;
      o_old_pdst <= old_n;
      o_ctrl     <= i_ctrl;
    end else if (i_ready) begin
      o_valid <= '0;
    end
  end

  assign o_free_count = count;

endmodule

// File: tb/tb_rename_map.sv
// tb/tb_rename_map.sv - self-checking bench for rename_map
module tb_rename_map;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [1:0] valid, regwrite;
  logic [1:0][4:0] src0, src1, dst;
  logic [1:0][CW-1:0] ctrl;
  logic rdy_in;
  logic [1:0] fv;
  logic [1:0][6:0] fp;
  logic ready;
  logic [1:0] ov;
  logic [1:0][6:0] psrc0, psrc1, pdst, old;
  logic [1:0][CW-1:0] octrl;
  logic [7:0] fcount;
  logic err;

  rename_map #(.NUM_AREGS(32), .NUM_PREGS(128), .CTRL_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_src0(src0), .i_src1(src1),
    .i_dst(dst), .i_regwrite(regwrite), .i_ctrl(ctrl), .o_ready(ready),
    .i_ready(rdy_in), .o_valid(ov), .o_psrc0(psrc0), .o_psrc1(psrc1),
    .o_pdst(pdst), .o_old_pdst(old), .o_ctrl(octrl), .i_free_valid(fv),
    .i_free_preg(fp), .o_free_count(fcount), .o_err(err)
  );

  int errors = 0;
  int checks = 0;

  // reference model: RAT as an array, free list as a queue, lanes renamed in order
  int m_rat[32];
  int m_fl[$];
  logic [1:0] m_ov;
  logic [1:0][6:0] m_ps0, m_ps1, m_pd, m_old;
  logic [1:0][CW-1:0] m_ctrl;
  logic m_err;
  bit m_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_need();
    int n = 0;
    for (int k = 0; k < 2; k++)
      if (valid[k] && regwrite[k] && dst[k] != 0) n++;
    return n;
  endfunction

  function automatic bit m_ready();
    return ((m_ov == 2'b00) || rdy_in) && (m_fl.size() >= m_need());
  endfunction

  task automatic m_reset();
    for (int a = 0; a < 32; a++) m_rat[a] = a;
    m_fl.delete();
    for (int p = 32; p < 128; p++) m_fl.push_back(p);
    m_ov = '0; m_ps0 = '0; m_ps1 = '0; m_pd = '0; m_old = '0; m_ctrl = '0;
    m_err = 1'b0;
  endtask

  task automatic m_step();
    m_acc = 1'b0;
    if (rst) begin
      m_reset();
      return;
    end
    if ((valid != 2'b00) && m_ready()) begin
      m_acc = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_ps0[k] = 7'(m_rat[src0[k]]);
        m_ps1[k] = 7'(m_rat[src1[k]]);
        if (valid[k] && regwrite[k] && dst[k] != 0) begin
          m_old[k] = 7'(m_rat[dst[k]]);
          m_pd[k]  = 7'(m_fl.pop_front());
          m_rat[dst[k]] = m_pd[k];
        end else begin
          m_old[k] = '0;
          m_pd[k]  = '0;
        end
      end
      m_ov = valid;
      m_ctrl = ctrl;
    end else if (rdy_in) begin
      m_ov = '0;
    end
    for (int k = 0; k < 2; k++)
      if (fv[k] && fp[k] != 0) begin
        if (m_fl.size() < 127) m_fl.push_back(fp[k]);
        else m_err = 1'b1;
      end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] rw, input int d0, input int d1,
                       input int a0, input int b0, input int a1, input int b1, input logic r);
    valid = v; regwrite = rw;
    dst[0] = 5'(d0); dst[1] = 5'(d1);
    src0[0] = 5'(a0); src1[0] = 5'(b0); src0[1] = 5'(a1); src1[1] = 5'(b1);
    ctrl[0] = $urandom; ctrl[1] = $urandom;
    rdy_in = r; fv = '0; fp = '0;
  endtask

  task automatic cycle();
    #1;
    chk("ready", {63'd0, ready}, {63'd0, m_ready()});
    @(posedge clk);
    m_step();
    @(negedge clk);
    chk("o_valid", 64'(ov), 64'(m_ov));
    chk("psrc0", 64'(psrc0), 64'(m_ps0));
    chk("psrc1", 64'(psrc1), 64'(m_ps1));
    chk("pdst", 64'(pdst), 64'(m_pd));
    chk("old_pdst", 64'(old), 64'(m_old));
    chk("ctrl", 64'(octrl), 64'(m_ctrl));
    chk("free_count", 64'(fcount), 64'(m_fl.size()));
    chk("err", 64'(err), 64'(m_err));
  endtask

  typedef struct {
    logic rst; logic [1:0] v, rw; int d0, d1, a0, b0, a1, b1; logic r;
    logic [1:0] fvv; int f0, f1;
    logic e_ready; logic [1:0] e_ov;
    int e_ps00, e_ps10, e_ps01, e_ps11, e_pd0, e_pd1, e_old0, e_old1, e_cnt;
  } vec_t;

  vec_t tbl[$];
  bit live[128];
  int rq[$];
  int alloc_total;
  int nlive;

  initial begin
    tbl.push_back('{0, 2'b11, 2'b11, 5, 6, 1, 2, 5, 0, 1, 2'b00, 0, 0, 1, 2'b11, 1, 2, 32, 0, 32, 33, 5, 6, 94});
    tbl.push_back('{1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 96});
    tbl.push_back('{0, 2'b11, 2'b11, 7, 7, 0, 0, 0, 0, 1, 2'b00, 0, 0, 1, 2'b11, 0, 0, 0, 0, 32, 33, 7, 32, 94});
    tbl.push_back('{0, 2'b01, 2'b00, 0, 0, 7, 6, 0, 0, 1, 2'b00, 0, 0, 1, 2'b01, 33, 6, 0, 0, 0, 0, 0, 0, 94});
    tbl.push_back('{0, 2'b11, 2'b01, 0, 9, 0, 0, 0, 0, 1, 2'b00, 0, 0, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 94});
    tbl.push_back('{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b11, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 94});
    tbl.push_back('{0, 2'b01, 2'b01, 3, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b01, 0, 0, 0, 0, 34, 0, 3, 0, 93});
    tbl.push_back('{0, 2'b01, 2'b01, 4, 0, 3, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b01, 0, 0, 0, 0, 34, 0, 3, 0, 93});
    tbl.push_back('{0, 2'b01, 2'b01, 4, 0, 3, 0, 0, 0, 1, 2'b00, 0, 0, 1, 2'b01, 34, 0, 0, 0, 35, 0, 4, 0, 92});

    rst = 1'b1;
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_count", 64'(fcount), 64'd96);
    chk("rst_valid", 64'(ov), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_pdst", 64'(pdst), 64'd0);

    // directed sequence with constant expectations
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].rw, tbl[i].d0, tbl[i].d1, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, tbl[i].r);
      rst = tbl[i].rst;
      fv = tbl[i].fvv; fp[0] = 7'(tbl[i].f0); fp[1] = 7'(tbl[i].f1);
      #1 chk($sformatf("tbl%0d_ready", i), 64'(ready), 64'(tbl[i].e_ready));
      cycle();
      chk($sformatf("tbl%0d_ov", i), 64'(ov), 64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_psrc", i), {psrc0[0], psrc1[0], psrc0[1], psrc1[1]},
          {7'(tbl[i].e_ps00), 7'(tbl[i].e_ps10), 7'(tbl[i].e_ps01), 7'(tbl[i].e_ps11)});
      chk($sformatf("tbl%0d_pdst", i), {pdst[0], pdst[1]}, {7'(tbl[i].e_pd0), 7'(tbl[i].e_pd1)});
      chk($sformatf("tbl%0d_old", i), {old[0], old[1]}, {7'(tbl[i].e_old0), 7'(tbl[i].e_old1)});
      chk($sformatf("tbl%0d_count", i), 64'(fcount), 64'(tbl[i].e_cnt));
    end
    rst = 1'b0;

    // drain to one entry, then stall a two-wide group while freeing 40
    for (int i = 0; i < 45; i++) begin
      drive(2'b11, 2'b11, 1 + (i % 15), 16 + (i % 15), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31), 1'b1);
      cycle();
    end
    drive(2'b01, 2'b01, 9, 0, 1, 2, 0, 0, 1'b1);
    cycle();
    chk("drain_count", 64'(fcount), 64'd1);
    drive(2'b11, 2'b11, 10, 11, 0, 0, 0, 0, 1'b1);
    fv = 2'b01; fp[0] = 7'd40;
    #1 chk("drain_stall_ready", 64'(ready), 64'd0);
    cycle();
    chk("drain_free_count", 64'(fcount), 64'd2);
    chk("drain_stall_ov", 64'(ov), 64'd0);
    drive(2'b11, 2'b11, 10, 11, 0, 0, 0, 0, 1'b1);
    #1 chk("drain_resume_ready", 64'(ready), 64'd1);
    cycle();
    chk("drain_pdst", {pdst[0], pdst[1]}, {7'd127, 7'd40});
    chk("drain_empty", 64'(fcount), 64'd0);

    // overflow: push frees until capacity is exceeded
    rst = 1'b1;
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
      fv = 2'b11; fp[0] = 7'(1 + i); fp[1] = 7'(20 + i);
      cycle();
    end
    chk("ovf_count", 64'(fcount), 64'd127);
    chk("ovf_err", 64'(err), 64'd1);
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    cycle();
    chk("ovf_err_sticky", 64'(err), 64'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("ovf_err_cleared", 64'(err), 64'd0);

    // randomized traffic with retire frees; tracks live pregs for duplicates
    for (int p = 0; p < 128; p++) live[p] = (p >= 1 && p < 32);
    alloc_total = 0;
    for (int i = 0; i < 500; i++) begin
      drive(2'($urandom_range(1, 3)), ($urandom % 4 != 0) ? 2'b11 : 2'($urandom),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
            ($urandom % 4 != 0));
      if ($urandom % 8 == 0) valid = 2'b00;
      for (int k = 0; k < 2; k++) begin
        if (rq.size() > 0 && $urandom % 4 != 0) begin
          fv[k] = 1'b1;
          fp[k] = 7'(rq.pop_front());
          live[fp[k]] = 1'b0;
        end else if ($urandom % 16 == 0) begin
          fv[k] = 1'b1;
          fp[k] = '0;
        end
      end
      cycle();
      if (m_acc)
        for (int k = 0; k < 2; k++)
          if (pdst[k] != 0 && ov[k]) begin
            chk("dup_alloc", 64'(live[pdst[k]]), 64'd0);
            live[pdst[k]] = 1'b1;
            alloc_total++;
            if (old[k] != 0) rq.push_back(int'(old[k]));
          end
      nlive = 0;
      for (int p = 0; p < 128; p++) nlive += int'(live[p]);
      chk("count_consistent", 64'(int'(fcount) + nlive), 64'd127);
    end
    chk("alloc_total_ge_200", 64'(alloc_total >= 200), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rename_map.md
# rename_map

Two-wide register-rename stage sitting directly upstream of dispatch. Each cycle it accepts up to two decoded instructions, maps architectural sources through the register alias table (RAT), and allocates fresh physical destinations from a circular free list. It emits the renamed pair one cycle later, including the previous mapping (old destination) that the ROB returns to the free list at retire. Retire frees are pushed back into the free list.

## Interface
- NUM_AREGS, 32, architectural registers; arch reg 0 is hardwired zero.
- NUM_PREGS, 128, physical registers; power of two; preg 0 is hardwired zero and never allocated or freed.
- CTRL_W, 32, opaque per-lane control/immediate bits passed through unchanged.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  2  per-lane instruction valid; lane 0 is older.
- i_src0, i_src1, i_dst  in  2x5 each  per-lane architectural source/destination.
- i_regwrite  in  2  lane writes a destination.
- i_ctrl  in  2xCTRL_W  pass-through payload.
- o_ready  out  1  group accepted this cycle when any i_valid bit is set and o_ready is high.
- i_ready  in  1  dispatch can take the output register contents.
- o_valid  out  2  per-lane output valid.
- o_psrc0, o_psrc1, o_pdst, o_old_pdst  out  2x7 each  renamed fields.
- o_ctrl  out  2xCTRL_W  registered i_ctrl.
- i_free_valid  in  2  retire frees this cycle.
- i_free_preg  in  2x7  physical registers to free.
- o_free_count  out  8  current free-list occupancy.
- o_err  out  1  sticky error: free-list overflow, or a free of a register already in the list beyond capacity.

## Operation
- Reset: RAT[a]=a for all a. Free list holds pregs 32..127 in ascending order. Head=0, tail=96, count=96. o_valid=0, o_err=0, o_free_count=96. All output data fields are 0.
- Lane allocates iff i_valid[k], i_regwrite[k], and i_dst[k]!=0. need = number of allocating lanes (0..2).
- o_ready = (o_valid==0 || i_ready) && (count >= need). The stall is all-or-nothing: a group is never split.
- On accept:
  - Lane 0 allocates free_list[head]. Lane 1 allocates the next entry: head+1 if lane 0 allocated, else head.
  - head advances by need, modulo NUM_PREGS.
- Non-allocating lane: o_pdst=0 and o_old_pdst=0.
- Sources: psrc = RAT[src]. Arch reg 0 always maps to preg 0.
- Intra-group bypass (lane 1 only):
  - If lane 0 allocates and lane 1's src0/src1 equals i_dst[0], that source gets lane 0's new preg.
  - If both lanes allocate the same dst, lane 1's o_old_pdst = lane 0's new preg, and the RAT ends holding lane 1's preg.
- RAT write for each allocating lane happens at the accepting edge, so the next group sees the new mappings.
- Frees:
  - Each i_free_valid lane with preg!=0 is written at tail. Lane 0 is written first; tail advances by the number pushed.
  - A free of preg 0 is ignored.
  - If count would exceed NUM_PREGS-1, the push is dropped and o_err sets, cleared only by reset.
- Count update: count_next = count - need_accepted + frees_pushed. Freed entries are not allocatable until the cycle after the push; o_ready uses the pre-update count.
- Output register:
  - Loads on accept with o_valid[k]=i_valid[k].
  - On i_ready with no new accept, it clears to o_valid=0.
  - When neither happens it holds all fields.

## Timing
- Latency: accepted group appears on outputs at the next rising edge (1 cycle).
- Throughput: 2 instructions/cycle with no stalls.
- o_ready is combinational from i_valid, i_regwrite, i_dst, i_ready, and the count register. It does not depend on the current cycle's frees.
- Reset mid-operation: the output register, RAT, free list, and count all return to reset values on the next edge. Frees and accepts in that cycle are ignored.
- Head/tail wrap from 127 to 0 without a bubble.

## Test plan
- Reset, then lane0 (dst=5, src0=1, src1=2) and lane1 (dst=6, src0=5, src1=0), with i_ready=1. Required next cycle:
  - lane0: psrc=1,2, pdst=32, old=5.
  - lane1: psrc0=32 (bypass), psrc1=0, pdst=33, old=6.
  - o_free_count=94.
- Both lanes dst=7: lane0 pdst=32 old=7; lane1 pdst=33 old=32. A following read of src=7 yields 33.
- Drain the list to count=1, then present a two-allocating group. Required: o_ready=0 and nothing changes. Free preg 40; next cycle count=2, o_ready=1, allocating the remaining entry then 40.
- Hold i_ready=0 with o_valid set and present a new group. Required: o_ready=0 and outputs held. Raise i_ready: the new group appears one cycle later.
- Lanes with dst=0 or regwrite=0: pdst=0, old=0, count unchanged. A free of preg 0 leaves count unchanged. Exceeding 127 entries sets o_err.
- Allocate 200 times with matching frees. Verify head/tail wrap, no duplicate allocation among live pregs, and that count stays consistent.
